// File: rtl/xbar_addr_arbiter_pkg.sv
// Shared crossbar parameters, index-width helper and arbiter FSM state type.
package xbar_addr_arbiter_pkg;

  localparam int XBAR_NUM_MST = 3;
  localparam int XBAR_ADDR_W  = 32;
  localparam int XBAR_ID_W    = 6;
  localparam int XBAR_USER_W  = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/xbar_addr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: lowest requester at or above the pointer,
// otherwise wrap to the lowest requester overall.
module rr_arbiter
  import xbar_addr_arbiter_pkg::*;
#(
  parameter  int NUM_MST = XBAR_NUM_MST,
  localparam int IDX_W   = idx_w(NUM_MST)
) (
  input  logic [NUM_MST-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_MST-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o
);

  logic [NUM_MST-1:0] hi_mask;
  logic [NUM_MST-1:0] hi_req;

  generate
    for (genvar gi = 0; gi < NUM_MST; gi++) begin : g_mask
      assign hi_mask[gi] = (gi >= int'(ptr_i));
    end
  endgenerate

  assign hi_req = req_i & hi_mask;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = |req_i;
    // Descending scans leave the lowest hit; the masked pass overrides the wrap pass.
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (req_i[i]) gnt_idx_o = IDX_W'(i);
    end
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (hi_req[i]) gnt_idx_o = IDX_W'(i);
    end
    for (int i = 0; i < NUM_MST; i++) begin
      gnt_o[i] = gnt_valid_o && (int'(gnt_idx_o) == i);
    end
  end

endmodule

// File: rtl/xbar_addr_arbiter.sv
// Address-channel arbiter: round-robin over masters into a single output
// register, with an outstanding-transaction limiter and sticky underflow flag.
module xbar_addr_arbiter
  import xbar_addr_arbiter_pkg::*;
#(
  parameter  int NUM_MST = XBAR_NUM_MST,
  parameter  int ADDR_W  = XBAR_ADDR_W,
  parameter  int ID_W    = XBAR_ID_W,
  parameter  int USER_W  = XBAR_USER_W,
  parameter  int MAX_OUT = 8,
  localparam int IDX_W   = idx_w(NUM_MST),
  localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_MST-1:0]              m_valid_i,
  output logic [NUM_MST-1:0]              m_ready_o,
  input  logic [NUM_MST-1:0][ADDR_W-1:0]  m_addr_i,
  input  logic [NUM_MST-1:0][ID_W-1:0]    m_id_i,
  input  logic [NUM_MST-1:0][USER_W-1:0]  m_user_i,
  output logic                            s_valid_o,
  input  logic                            s_ready_i,
  output logic [ADDR_W-1:0]               s_addr_o,
  output logic [USER_W-1:0]               s_user_o,
  output logic [ID_W+IDX_W-1:0]           s_id_o,
  input  logic                            resp_done_i,
  output logic [CNT_W-1:0]                outstanding_o,
  output logic                            underflow_o
);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [ID_W+IDX_W-1:0]   id_q, id_d;
  logic [USER_W-1:0]       user_q, user_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    uf_q, uf_d;

  logic                    busy;
  logic                    handshake;
  logic                    room;
  logic                    grant_en;
  logic [NUM_MST-1:0]      req;
  logic [NUM_MST-1:0]      gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    gnt_valid;

  assign busy      = (state_q == ST_BUSY);
  assign handshake = busy && s_ready_i && !rst_i;
  // The held request is already committed, so it occupies a slot until its handshake.
  assign room      = (int'(cnt_q) + int'(busy)) < MAX_OUT;
  assign grant_en  = !rst_i && (!busy || s_ready_i) && room;
  assign req       = m_valid_i & {NUM_MST{grant_en}};

  rr_arbiter #(
    .NUM_MST (NUM_MST)
  ) u_rr (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    id_d    = id_q;
    user_d  = user_q;
    case (state_q)
      ST_IDLE: if (gnt_valid) state_d = ST_BUSY;
      ST_BUSY: if (s_ready_i && !gnt_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (gnt_valid) begin
      addr_d = m_addr_i[gnt_idx];
      id_d   = {gnt_idx, m_id_i[gnt_idx]};
      user_d = m_user_i[gnt_idx];
      ptr_d  = (int'(gnt_idx) == NUM_MST - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    uf_d  = uf_q;
    case ({handshake, resp_done_i})
      2'b10: cnt_d = cnt_q + 1'b1;
      2'b01: begin
        if (cnt_q == '0) uf_d = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      id_q    <= '0;
      user_q  <= '0;
      cnt_q   <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      user_q  <= user_d;
      cnt_q   <= cnt_d;
      uf_q    <= uf_d;
    end
  end

  assign m_ready_o     = gnt;
  assign s_valid_o     = busy && !rst_i;
  assign s_addr_o      = addr_q;
  assign s_id_o        = id_q;
  assign s_user_o      = user_q;
  assign outstanding_o = cnt_q;
  assign underflow_o   = uf_q;

endmodule

// File: tb/tb_xbar_addr_arbiter.sv
// Directed scenarios plus randomized traffic, checked each cycle against a
// transaction-level reference model of the arbiter.
module tb_xbar_addr_arbiter;

  localparam int NUM_MST = 3;
  localparam int ADDR_W  = 32;
  localparam int ID_W    = 6;
  localparam int USER_W  = 8;
  localparam int MAX_OUT = 2;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 2;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NUM_MST-1:0]             m_valid;
  logic [NUM_MST-1:0]             m_ready_o;
  logic [NUM_MST-1:0][ADDR_W-1:0] m_addr;
  logic [NUM_MST-1:0][ID_W-1:0]   m_id;
  logic [NUM_MST-1:0][USER_W-1:0] m_user;
  logic                           s_valid_o;
  logic                           s_ready;
  logic [ADDR_W-1:0]              s_addr_o;
  logic [USER_W-1:0]              s_user_o;
  logic [ID_W+IDX_W-1:0]          s_id_o;
  logic                           resp_done;
  logic [CNT_W-1:0]               outstanding_o;
  logic                           underflow_o;

  always #5 clk = ~clk;

  xbar_addr_arbiter #(
    .NUM_MST (NUM_MST),
    .ADDR_W  (ADDR_W),
    .ID_W    (ID_W),
    .USER_W  (USER_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .m_valid_i     (m_valid),
    .m_ready_o     (m_ready_o),
    .m_addr_i      (m_addr),
    .m_id_i        (m_id),
    .m_user_i      (m_user),
    .s_valid_o     (s_valid_o),
    .s_ready_i     (s_ready),
    .s_addr_o      (s_addr_o),
    .s_user_o      (s_user_o),
    .s_id_o        (s_id_o),
    .resp_done_i   (resp_done),
    .outstanding_o (outstanding_o),
    .underflow_o   (underflow_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: one held request slot, a pointer, a count, a sticky flag.
  bit          mdl_valid;
  int          mdl_idx;
  logic [31:0] mdl_addr;
  logic [5:0]  mdl_id;
  logic [7:0]  mdl_user;
  int          mdl_ptr;
  int          mdl_cnt;
  bit          mdl_uf;

  int grant_log[$];
  int sid_log[$];
  bit saw_m2;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mdl_valid = 1'b0;
    mdl_idx   = 0;
    mdl_addr  = '0;
    mdl_id    = '0;
    mdl_user  = '0;
    mdl_ptr   = 0;
    mdl_cnt   = 0;
    mdl_uf    = 1'b0;
  endtask

  task automatic drive(input logic [2:0] v, input bit rdy, input bit done);
    m_valid   = v;
    s_ready   = rdy;
    resp_done = done;
    for (int j = 0; j < NUM_MST; j++) begin
      m_addr[j] = $urandom;
      m_id[j]   = 6'($urandom);
      m_user[j] = 8'($urandom);
    end
  endtask

  // Called just after a negedge with inputs set; checks, advances model, returns at next negedge.
  task automatic step();
    int win;
    bit can;
    bit hs;
    logic [2:0] exp_rdy;
    #1;
    win = -1;
    can = !rst && (!mdl_valid || s_ready) && ((mdl_cnt + (mdl_valid ? 1 : 0)) < MAX_OUT);
    if (can) begin
      for (int k = 0; k < NUM_MST; k++) begin
        if (win < 0 && m_valid[(mdl_ptr + k) % NUM_MST]) win = (mdl_ptr + k) % NUM_MST;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check_eq("m_ready", m_ready_o, exp_rdy);
    check_eq("s_valid", s_valid_o, mdl_valid && !rst);
    if (mdl_valid) begin
      check_eq("s_addr", s_addr_o, mdl_addr);
      check_eq("s_id", s_id_o, (mdl_idx << ID_W) | mdl_id);
      check_eq("s_user", s_user_o, mdl_user);
    end
    check_eq("outstanding", outstanding_o, mdl_cnt);
    check_eq("underflow", underflow_o, mdl_uf);
    for (int j = 0; j < NUM_MST; j++) if (m_ready_o[j]) grant_log.push_back(j);
    if (m_ready_o[2]) saw_m2 = 1'b1;
    if (s_valid_o && s_ready) begin
      sid_log.push_back(int'(s_id_o[7:6]));
      $display("cycle %0d: handshake id=%0h addr=%0h user=%0h outstanding=%0d",
               cyc, s_id_o, s_addr_o, s_user_o, outstanding_o);
    end
    hs = mdl_valid && s_ready && !rst;
    if (rst) begin
      model_reset();
    end else begin
      if (hs && !resp_done) mdl_cnt++;
      else if (!hs && resp_done) begin
        if (mdl_cnt == 0) mdl_uf = 1'b1;
        else mdl_cnt--;
      end
      if (win >= 0) begin
        mdl_valid = 1'b1;
        mdl_idx   = win;
        mdl_addr  = m_addr[win];
        mdl_id    = m_id[win];
        mdl_user  = m_user[win];
        mdl_ptr   = (win + 1) % NUM_MST;
      end else if (hs) begin
        mdl_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (!mdl_valid && mdl_cnt == 0) break;
      drive(3'b000, 1'b1, mdl_cnt > 0);
      step();
    end
    check_eq("drain_outstanding", outstanding_o, 0);
    check_eq("drain_svalid", s_valid_o, 0);
  endtask

  task automatic pulse_reset();
    drive(3'b000, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(3'b000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rst_svalid", s_valid_o, 0);
    check_eq("rst_mready", m_ready_o, 0);
    check_eq("rst_outstanding", outstanding_o, 0);
    check_eq("rst_underflow", underflow_o, 0);
    check_eq("rst_saddr", s_addr_o, 0);
    check_eq("rst_sid", s_id_o, 0);
    check_eq("rst_suser", s_user_o, 0);
    model_reset();
    rst = 1'b0;

    // Round-robin with all masters requesting and the slave always ready.
    grant_log.delete();
    sid_log.delete();
    for (int i = 0; i < 4; i++) begin
      drive(3'b111, 1'b1, mdl_valid);
      step();
    end
    drive(3'b000, 1'b1, 1'b1);
    step();
    check_eq("rr_ngrants", grant_log.size(), 4);
    check_eq("rr_nhs", sid_log.size(), 4);
    if (grant_log.size() == 4 && sid_log.size() == 4) begin
      check_eq("rr_g0", grant_log[0], 0);
      check_eq("rr_g1", grant_log[1], 1);
      check_eq("rr_g2", grant_log[2], 2);
      check_eq("rr_g3", grant_log[3], 0);
      check_eq("rr_id0", sid_log[0], 0);
      check_eq("rr_id1", sid_log[1], 1);
      check_eq("rr_id2", sid_log[2], 2);
      check_eq("rr_id3", sid_log[3], 0);
    end
    drain();

    // Backpressure: payload held stable while the slave stalls.
    drive(3'b010, 1'b0, 1'b0);
    m_id[1]   = 6'h2A;
    m_addr[1] = 32'h1000_0040;
    step();
    for (int i = 0; i < 5; i++) begin
      drive(3'b000, 1'b0, 1'b0);
      step();
      check_eq("stall_svalid", s_valid_o, 1);
      check_eq("stall_sid", s_id_o, 8'h6A);
      check_eq("stall_saddr", s_addr_o, 32'h1000_0040);
    end
    sid_log.delete();
    drive(3'b000, 1'b1, 1'b0);
    step();
    check_eq("stall_nhs", sid_log.size(), 1);
    check_eq("stall_outstanding", outstanding_o, 1);

    // Handshake and response in the same cycle at count 1.
    drive(3'b001, 1'b1, 1'b0);
    step();
    drive(3'b000, 1'b1, 1'b1);
    step();
    check_eq("same_cycle_cnt", outstanding_o, 1);
    drain();

    // Outstanding limit of two blocks the third master until a response.
    pulse_reset();
    grant_log.delete();
    saw_m2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(3'b111, 1'b1, 1'b0);
      step();
    end
    check_eq("limit_ngrants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check_eq("limit_g0", grant_log[0], 0);
      check_eq("limit_g1", grant_log[1], 1);
    end
    check_eq("limit_cnt", outstanding_o, 2);
    check_eq("limit_m2_blocked", saw_m2, 0);
    drive(3'b111, 1'b1, 1'b1);
    step();
    drive(3'b111, 1'b1, 1'b0);
    #1;
    check_eq("limit_m2_grant", m_ready_o, 3'b100);
    step();

    // Underflow is sticky until reset.
    pulse_reset();
    drive(3'b000, 1'b0, 1'b1);
    step();
    check_eq("uf_set", underflow_o, 1);
    for (int i = 0; i < 3; i++) begin
      drive(3'b000, 1'b0, 1'b0);
      step();
      check_eq("uf_hold", underflow_o, 1);
    end
    pulse_reset();
    check_eq("uf_clear", underflow_o, 0);

    // Reset mid-transfer discards the held request and restores priority.
    drive(3'b001, 1'b0, 1'b0);
    step();
    drive(3'b000, 1'b0, 1'b0);
    step();
    check_eq("mid_busy", s_valid_o, 1);
    drive(3'b000, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_svalid", s_valid_o, 0);
    check_eq("mid_cnt", outstanding_o, 0);
    drive(3'b111, 1'b1, 1'b0);
    #1;
    check_eq("mid_first_grant", m_ready_o, 3'b001);
    step();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      drive(3'($urandom), ($urandom % 100) < 70,
            (($urandom % 100) < 35) && (mdl_cnt > 0 || ($urandom % 60) == 0));
      rst = (($urandom % 90) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xbar_addr_arbiter.md
XBAR_ADDR_ARBITER -- requirements
Module: xbar_addr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MST, default 3, number of upstream master ports (1..16).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter ID_W, default 6, upstream ID width.
REQ-004 SHALL have parameter USER_W, default 8, user sideband width.
REQ-005 SHALL have parameter MAX_OUT, default 8, maximum outstanding transactions (1..255).
REQ-006 SHALL have clk_i  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have rst_i  in  1  reset, synchronous, active-high.
REQ-008 SHALL have m_valid_i  in  NUM_MST  per-master request valid.
REQ-009 SHALL have m_ready_o  out  NUM_MST  per-master request accept.
REQ-010 SHALL have m_addr_i / m_id_i / m_user_i  in  NUM_MST x ADDR_W / ID_W / USER_W  per-master payload.
REQ-011 SHALL have s_valid_o  out  1, s_ready_i  in  1  downstream slave-port handshake.
REQ-012 SHALL have s_addr_o  out  ADDR_W, s_user_o  out  USER_W, s_id_o  out  ID_W+IDX_W  forwarded payload; IDX_W = max(1, clog2(NUM_MST)).
REQ-013 SHALL have resp_done_i  in  1  one-cycle pulse per completed response.
REQ-014 SHALL have outstanding_o  out  clog2(MAX_OUT+1)  current outstanding count.
REQ-015 SHALL have underflow_o  out  1  sticky error flag.

Function
REQ-016 SHALL implement FSM with states IDLE (output register empty) and BUSY (output register holds request, s_valid_o=1).
REQ-017 SHALL, when output register is empty or draining (BUSY and s_ready_i=1), and outstanding count plus pending captures < MAX_OUT, grant exactly one requesting master by round-robin and assert its m_ready_o that cycle.
REQ-018 SHALL capture granted payload into output register on the grant edge; s_valid_o rises the following cycle (latency 1).
REQ-019 SHALL form s_id_o = {granted master index, m_id_i}, index zero-extended to IDX_W.
REQ-020 SHALL hold s_valid_o and all s_* payload stable while s_valid_o=1 and s_ready_i=0.
REQ-021 SHALL transition BUSY->IDLE on s_ready_i=1 with no new grant; BUSY->BUSY on s_ready_i=1 with new grant (back-to-back, one request per cycle).
REQ-022 SHALL rotate priority to (granted index + 1) mod NUM_MST after each grant; unchanged when no grant.
REQ-023 SHALL increment outstanding count on each s_valid_o && s_ready_i handshake and decrement on resp_done_i; both in same cycle leaves count unchanged.
REQ-024 SHALL block new grants while count == MAX_OUT, counting a request held in the output register as pending.
REQ-025 SHALL, on resp_done_i with count == 0 and no same-cycle handshake, keep count at 0 and set underflow_o until reset.
REQ-026 SHALL never assert more than one m_ready_o bit per cycle, and never assert one whose m_valid_i is low.

Reset
REQ-027 SHALL, while rst_i=1, force state IDLE, s_valid_o=0, m_ready_o=0, outstanding_o=0, underflow_o=0, priority pointer=0, s_* payload=0.
REQ-028 SHALL discard a request held in BUSY when reset asserts mid-transfer; no handshake is counted.

Structure
REQ-029 SHALL take defaults for ADDR_W, ID_W, USER_W, NUM_MST from the shared xbar parameter package; IDX_W helper function and FSM state enum SHALL live in that package.
REQ-030 SHALL instantiate one sub-module rr_arbiter (parametrised on NUM_MST; request vector and pointer in, one-hot grant and index out, purely combinational).

Verification
REQ-031 SHALL cover: m_valid_i=3'b111 held, s_ready_i=1 -> grants in order 0,1,2,0; s_id_o upper bits 0,1,2,0.
REQ-032 SHALL cover: master 1 request id=6'h2A addr=32'h1000_0040, s_ready_i low 5 cycles -> s_valid_o and payload stable 5 cycles, s_id_o=8'h6A, then one handshake.
REQ-033 SHALL cover: MAX_OUT=2, three requests, no resp_done_i -> two handshakes, third master m_ready_o stays 0; one resp_done_i pulse -> third granted next cycle.
REQ-034 SHALL cover: count=1, handshake and resp_done_i same cycle -> outstanding_o stays 1.
REQ-035 SHALL cover: resp_done_i at count 0 -> underflow_o=1 and persists; rst_i pulse -> 0.
REQ-036 SHALL cover: rst_i asserted while BUSY -> next cycle s_valid_o=0, outstanding_o=0, next grant goes to master 0.
